// File: rtl/ex_stage.sv
// RV32IM execute stage feeding the EX/MEM register; single-cycle ALU plus optional divider.
// Define EX_DIV_EN to build the iterative divider for DIV/DIVU/REM/REMU (otherwise they return 0).
module ex_stage #(
   parameter int unsigned XLEN               = 32,
   parameter int unsigned DIV_BITS_PER_CYCLE = 1,
   parameter type         control_type       = logic [15:0]
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic [3:0]        alu_op,
   input  logic [XLEN-1:0]   operand_a,
   input  logic [XLEN-1:0]   operand_b,
   input  logic [XLEN-1:0]   store_data_in,
   input  control_type       control_in,
   input  logic              stall_in,
   input  logic              flush,
   output logic              busy,
   output logic              valid_out,
   output logic [XLEN-1:0]   alu_data_out,
   output logic [XLEN-1:0]   memory_data_out,
   output control_type       control_out
);

   logic              valid_q;
   logic [XLEN-1:0]   alu_q;
   logic [XLEN-1:0]   mem_q;
   control_type       ctrl_q;

   logic [XLEN-1:0]   alu_res;
   logic [4:0]        shamt;
   logic              div_done;
   logic [XLEN-1:0]   div_res;

   assign shamt = operand_b[4:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'd0:    alu_res = operand_a + operand_b;
         4'd1:    alu_res = operand_a - operand_b;
         4'd2:    alu_res = operand_a << shamt;
         4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
         4'd4:    alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
         4'd5:    alu_res = operand_a ^ operand_b;
         4'd6:    alu_res = operand_a >> shamt;
         4'd7:    alu_res = $signed(operand_a) >>> shamt;
         4'd8:    alu_res = operand_a | operand_b;
         4'd9:    alu_res = operand_a & operand_b;
         4'd10:   alu_res = operand_b;
         4'd11:   alu_res = operand_a * operand_b;
         default: alu_res = '0;
      endcase
   end

`ifdef EX_DIV_EN
   localparam int unsigned NIter = XLEN / DIV_BITS_PER_CYCLE;
   localparam int unsigned CntW  = (NIter > 1) ? $clog2(NIter) : 1;

   typedef enum logic [1:0] {StIdle, StDiv, StDone} div_state_e;

   div_state_e        state_q;
   logic [CntW-1:0]   cnt_q;
   logic [XLEN-1:0]   dvs_q, quot_q, rem_q;
   logic [XLEN-1:0]   quot_n, rem_n, quot_fix, rem_fix;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     shifted, trial;
   logic              neg_quot_q, neg_rem_q, is_rem_q;
   logic              is_div_op, a_neg, b_neg;

   assign is_div_op = alu_op[3] & alu_op[2];
   assign a_neg     = ~alu_op[0] & operand_a[XLEN-1];
   assign b_neg     = ~alu_op[0] & operand_b[XLEN-1];
   assign mag_a     = a_neg ? -operand_a : operand_a;
   assign mag_b     = b_neg ? -operand_b : operand_b;

   assign busy = reset_n & ((state_q == StDiv) |
                            ((state_q == StIdle) & valid_in & is_div_op));
   assign div_done = (state_q == StDone);

   // Restoring division; a zero divisor naturally yields all-ones quotient and rem = dividend.
   always_comb begin
      rem_n   = rem_q;
      quot_n  = quot_q;
      shifted = '0;
      trial   = '0;
      for (int unsigned i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
         shifted = {rem_n, quot_n[XLEN-1]};
         trial   = shifted - {1'b0, dvs_q};
         quot_n  = {quot_n[XLEN-2:0], ~trial[XLEN]};
         rem_n   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      end
   end

   always_comb begin
      quot_fix = neg_quot_q ? -quot_q : quot_q;
      rem_fix  = neg_rem_q ? -rem_q : rem_q;
      div_res  = is_rem_q ? rem_fix : quot_fix;
   end
`else
   assign busy     = 1'b0;
   assign div_done = 1'b0;
   assign div_res  = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         alu_q      <= '0;
         mem_q      <= '0;
         ctrl_q     <= '0;
`ifdef EX_DIV_EN
         state_q    <= StIdle;
         cnt_q      <= '0;
         dvs_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         is_rem_q   <= 1'b0;
`endif
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
`ifdef EX_DIV_EN
         state_q <= StIdle;
         cnt_q   <= '0;
`endif
      end else begin
         if (!stall_in) begin
            if (div_done) begin
               valid_q <= 1'b1;
               alu_q   <= div_res;
               mem_q   <= store_data_in;
               ctrl_q  <= control_in;
            end else if (valid_in && !busy) begin
               valid_q <= 1'b1;
               alu_q   <= alu_res;
               mem_q   <= store_data_in;
               ctrl_q  <= control_in;
            end else begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
            end
         end
`ifdef EX_DIV_EN
         unique case (state_q)
            StIdle: begin
               if (valid_in && is_div_op) begin
                  state_q    <= StDiv;
                  cnt_q      <= CntW'(NIter - 1);
                  dvs_q      <= mag_b;
                  quot_q     <= mag_a;
                  rem_q      <= '0;
                  neg_quot_q <= (a_neg ^ b_neg) & (|operand_b);
                  neg_rem_q  <= a_neg;
                  is_rem_q   <= alu_op[1];
               end
            end
            StDiv: begin
               rem_q  <= rem_n;
               quot_q <= quot_n;
               cnt_q  <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= StDone;
            end
            StDone: begin
               if (!stall_in) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
`endif
      end
   end

   assign valid_out       = valid_q;
   assign alu_data_out    = alu_q;
   assign memory_data_out = mem_q;
   assign control_out     = ctrl_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus a randomized stream against a reference model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [3:0]  alu_op;
   logic [31:0] operand_a, operand_b, store_data_in;
   logic [15:0] control_in;
   logic        stall_in, flush;
   logic        busy, valid_out;
   logic [31:0] alu_data_out, memory_data_out;
   logic [15:0] control_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_sd;
   logic [15:0] exp_ctrl;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .valid_in        (valid_in),
      .alu_op          (alu_op),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .store_data_in   (store_data_in),
      .control_in      (control_in),
      .stall_in        (stall_in),
      .flush           (flush),
      .busy            (busy),
      .valid_out       (valid_out),
      .alu_data_out    (alu_data_out),
      .memory_data_out (memory_data_out),
      .control_out     (control_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb, p2;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      p2 = longint'(1) << b[4:0];
      case (op)
         4'd0:    return 32'(ua + ub);
         4'd1:    return 32'(ua - ub);
         4'd2:    return 32'(ua * p2);
         4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:    return (ua < ub) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return 32'(ua / p2);
         4'd7:    return (sa >= 0) ? 32'(sa / p2) : 32'(-((p2 - 1 - sa) / p2));
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         4'd11:   return 32'(ua * ub);
         default: return 32'd0;
      endcase
   endfunction

`ifdef EX_DIV_EN
   function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint n, d;
      if (op[0]) begin
         n = longint'({32'd0, a});
         d = longint'({32'd0, b});
      end else begin
         n = longint'($signed(a));
         d = longint'($signed(b));
      end
      if (d == 0) return op[1] ? a : 32'hFFFF_FFFF;
      return op[1] ? 32'(n % d) : 32'(n / d);
   endfunction
`endif

   task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      exp_sd        = $urandom;
      exp_ctrl      = 16'($urandom) | 16'h1;
      valid_in      = 1'b1;
      alu_op        = op;
      operand_a     = a;
      operand_b     = b;
      store_data_in = exp_sd;
      control_in    = exp_ctrl;
      stall_in      = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      present(op, a, b);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid"}, valid_out, 1);
      check_eq({tag, "_res"}, alu_data_out, exp);
      check_eq({tag, "_sdata"}, memory_data_out, exp_sd);
      check_eq({tag, "_ctrl"}, control_out, exp_ctrl);
      valid_in = 1'b0;
   endtask

`ifdef EX_DIV_EN
   task automatic do_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int   lat, bcnt, bub;
      logic got;
      present(op, a, b);
      #1;
      lat  = 0;
      bcnt = 0;
      bub  = 0;
      got  = 1'b0;
      while (!got && lat < 80) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
         if (valid_out) got = 1'b1;
         else if (control_out != '0) bub++;
      end
      valid_in = 1'b0;
      check_eq({tag, "_latency"}, lat, 34);
      check_eq({tag, "_busy_cycles"}, bcnt, 33);
      check_eq({tag, "_bubbles"}, bub, 0);
      check_eq({tag, "_res"}, alu_data_out, exp);
      check_eq({tag, "_sdata"}, memory_data_out, exp_sd);
      check_eq({tag, "_ctrl"}, control_out, exp_ctrl);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        m_valid;
      logic [31:0] m_alu, m_mem;
      logic [15:0] m_ctrl;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        v, st;

      m_valid = 1'b0;
      m_alu = '0;
      m_mem = '0;
      m_ctrl = '0;
      reset_n = 1'b0;
      valid_in = 1'b0;
      alu_op = '0;
      operand_a = '0;
      operand_b = '0;
      store_data_in = '0;
      control_in = '0;
      stall_in = 1'b0;
      flush = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", valid_out, 0);
      check_eq("rst_alu", alu_data_out, 0);
      check_eq("rst_mem", memory_data_out, 0);
      check_eq("rst_ctrl", control_out, 0);
      check_eq("rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset in the middle of traffic
      do_single("pre_add", 4'd0, 32'd3, 32'd4, 32'd7);
      @(negedge clk);
      valid_in  = 1'b1;
      alu_op    = 4'd12;
      operand_a = 32'd50;
      operand_b = 32'd5;
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_valid", valid_out, 0);
      check_eq("midrst_alu", alu_data_out, 0);
      check_eq("midrst_mem", memory_data_out, 0);
      check_eq("midrst_ctrl", control_out, 0);
      check_eq("midrst_busy", busy, 0);
      valid_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      do_single("add_5_7", 4'd0, 32'd5, 32'd7, 32'd12);
      do_single("sra", 4'd7, 32'hF000_0000, 32'd4, 32'hFF00_0000);
      do_single("sltu", 4'd4, 32'd1, 32'hFFFF_FFFF, 32'd1);
      do_single("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
      do_single("mul", 4'd11, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F);
      do_single("passb", 4'd10, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Randomized stream with bubbles and stalls
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         v  = ($urandom_range(0, 3) != 0);
         st = (i != 0) && ($urandom_range(0, 4) == 0);
`ifdef EX_DIV_EN
         op = 4'($urandom_range(0, 11));
`else
         op = 4'($urandom_range(0, 15));
`endif
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
         exp_sd = $urandom;
         exp_ctrl = 16'($urandom) | 16'h1;
         valid_in = v;
         alu_op = op;
         operand_a = a;
         operand_b = b;
         store_data_in = exp_sd;
         control_in = exp_ctrl;
         stall_in = st;
         if (!st) begin
            if (v) begin
               m_valid = 1'b1;
               m_alu   = ref_alu(op, a, b);
               m_mem   = exp_sd;
               m_ctrl  = exp_ctrl;
            end else begin
               m_valid = 1'b0;
               m_ctrl  = '0;
            end
         end
         @(posedge clk);
         #1;
         check_eq("rnd_valid", valid_out, m_valid);
         check_eq("rnd_ctrl", control_out, m_ctrl);
         if (m_valid) begin
            check_eq("rnd_alu", alu_data_out, m_alu);
            check_eq("rnd_mem", memory_data_out, m_mem);
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
      stall_in = 1'b0;

`ifdef EX_DIV_EN
      do_div("div_m7_2", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_div("rem_m7_2", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_div("divu_by0", 4'd13, 32'd100, 32'd0, 32'hFFFF_FFFF);
      do_div("remu_by0", 4'd15, 32'd100, 32'd0, 32'd100);
      do_div("div_by0_neg", 4'd12, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF);
      do_div("rem_by0_neg", 4'd14, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00);
      do_div("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_div("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(12, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
         do_div("div_rnd", op, a, b, ref_div(op, a, b));
      end

      // Flush part-way through a division
      present(4'd12, 32'd1000, 32'd7);
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_valid", valid_out, 0);
      check_eq("flush_busy", busy, 0);
      check_eq("flush_ctrl", control_out, 0);
      do_single("post_flush_add", 4'd0, 32'd20, 32'd22, 32'd42);
      begin
         int stray;
         stray = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) stray++;
         end
         check_eq("flush_no_late_result", stray, 0);
      end

      // Flush together with a divide request
      @(negedge clk);
      valid_in = 1'b1;
      alu_op = 4'd13;
      operand_a = 32'd77;
      operand_b = 32'd3;
      flush = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      flush = 1'b0;
      #1;
      check_eq("flush_start_valid", valid_out, 0);
      check_eq("flush_start_busy", busy, 0);

      // Stall held through DONE
      present(4'd13, 32'd1000, 32'd3);
      #1;
      begin
         int guard;
         guard = 0;
         while (busy && guard < 80) begin
            @(posedge clk);
            #1;
            guard++;
         end
         check_eq("stall_reach_done", guard, 33);
      end
      check_eq("done_busy", busy, 0);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("stall_done_valid", valid_out, 0);
         check_eq("stall_done_ctrl", control_out, 0);
         check_eq("stall_done_busy", busy, 0);
      end
      stall_in = 1'b0;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      check_eq("stall_release_valid", valid_out, 1);
      check_eq("stall_release_res", alu_data_out, 32'd333);
      check_eq("stall_release_ctrl", control_out, exp_ctrl);

      // Reset during a division
      present(4'd12, 32'd12345, 32'd67);
      repeat (5) @(posedge clk);
      #1;
      check_eq("rstdiv_busy_before", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rstdiv_busy", busy, 0);
      check_eq("rstdiv_valid", valid_out, 0);
      check_eq("rstdiv_alu", alu_data_out, 0);
      check_eq("rstdiv_ctrl", control_out, 0);
      valid_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_eq("rstdiv_idle_busy", busy, 0);
      do_single("rstdiv_add", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
      do_div("rstdiv_div", 4'd12, 32'd12345, 32'd67, 32'd184);
`else
      present(4'd15, 32'd100, 32'd7);
      #1;
      check_eq("nodiv_busy", busy, 0);
      @(posedge clk);
      #1;
      check_eq("nodiv_valid", valid_out, 1);
      check_eq("nodiv_res", alu_data_out, 0);
      check_eq("nodiv_ctrl", control_out, exp_ctrl);
      valid_in = 1'b0;
      do_single("nodiv_div", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- RV32IM execute stage, sitting directly upstream of the memory stage.
- Receives decoded operands and a control bundle from the ID/EX register.
- Computes the ALU result in one cycle. DIV/DIVU/REM/REMU run on an iterative divider that stalls the front end.
- Drives the EX/MEM pipeline register: alu_data_out, memory_data_out (store data) and control_out feed the memory stage directly.

Parameters:
- XLEN, 32: datapath width; only 32 is supported.
- DIV_BITS_PER_CYCLE, 1: quotient bits resolved per iteration; legal values 1 or 2. Iteration count N = XLEN/DIV_BITS_PER_CYCLE.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  ID/EX holds a valid instruction.
- alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- operand_a  in  32  rs1 or PC.
- operand_b  in  32  rs2 or immediate.
- store_data_in  in  32  rs2 value for stores.
- control_in  in  control_type  control bundle from common, passed through.
- stall_in  in  1  hazard unit freeze of the EX/MEM register.
- flush  in  1  kill the instruction in EX and abort the divider.
- busy  out  1  combinational; upstream must hold ID/EX while high.
- valid_out  out  1  EX/MEM entry valid.
- alu_data_out  out  32  registered result / memory address.
- memory_data_out  out  32  registered store data.
- control_out  out  control_type  registered control; all-zero when valid_out=0.

Behaviour:
- Reset (async, reset_n low):
  - valid_out=0, alu_data_out=0, memory_data_out=0, control_out all-zero.
  - FSM goes to IDLE; busy=0 while reset is asserted.
- Single-cycle ops (0-11):
  - The result is registered at the edge where valid_in=1 and stall_in=0. Latency is 1.
  - Shifts use operand_b[4:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
  - MUL produces the low 32 bits of the product.
  - PASSB produces operand_b.
  - All arithmetic wraps mod 2^32.
- Bubbles: valid_in=0 with stall_in=0 loads valid_out=0 and an all-zero control_out.
- Stall: stall_in=1 holds all EX/MEM outputs.
- Divider FSM states: IDLE, DIV, DONE.
  - IDLE → DIV when valid_in=1, the op is 12-15 and flush=0. Operand magnitudes and sign flags are latched; the counter is loaded with N-1.
  - DIV: one iteration per cycle; the counter decrements. At counter 0 the state goes to DONE.
  - DONE: if stall_in=0, the result, store data and control_in load EX/MEM, valid_out=1, and the state returns to IDLE. If stall_in=1, the state stays DONE.
- busy = (state==DIV) OR (state==IDLE AND valid_in AND op in 12-15).
  - busy=0 in DONE, so upstream advances on the same edge the result is written.
  - The held div instruction is therefore never restarted.
- Div latency: operand presentation to valid_out is N+2 cycles (34 at default).
- While busy, EX/MEM loads bubbles (valid_out=0) unless stall_in=1, in which case it holds.
- Signed ops: divide the magnitudes, then negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. This takes the same fixed latency.
- Overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- flush:
  - Priority over stall_in and over the FSM.
  - Next edge: valid_out=0, control_out zero, state IDLE, counter cleared.
  - Any in-flight division is discarded.
- Simultaneous events:
  - flush with an IDLE→DIV request: no division starts.
  - Reset mid-division: immediate abort; outputs take their reset values.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined (default build):
  - The iterative divider and FSM are present, as described above.
- Undefined:
  - Ops 12-15 complete in a single cycle with result 0.
  - busy is tied to 0 and no divider logic is synthesised.

Test Plan:
- Reset asserted mid-stream → all outputs zero immediately; after release, ADD 5+7 → alu_data_out=12, valid_out=1 one cycle later.
- SRA 0xF0000000 by 4; SLTU 1 vs 0xFFFFFFFF → 0xFF000000, then 1.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF.
  - busy high for exactly 33 cycles.
  - valid_out=1 on cycle 34; intermediate entries are bubbles.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Flush at iteration 10 of a DIV → next cycle valid_out=0, busy=0; a following ADD completes normally.
- Hold stall_in=1 through DONE for 3 cycles → outputs frozen, state stays DONE, busy=0; the result appears the cycle after stall_in falls.
